// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared definitions for the display RAM arbiter.
//   - Grant codes, also driven out on the tst debug port.
//   - FSM state encodings for the 3-cycle access sequence.
//   - Default RAM geometry (8K x 8).
package ram_arb_pkg;

  localparam int unsigned DEF_AW = 13;
  localparam int unsigned DEF_DW = 8;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_TFT  = 2'd1,
    GNT_STN  = 2'd2,
    GNT_HOST = 2'd3
  } gnt_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ram_arb_prio.sv
// ram_arb_prio: winner selection plus starvation counters.
// Ports:
//   clk, rst_x           clock, async active-low reset
//   tft_req, stn_req,
//   host_req             requester levels
//   arb                  commit strobe, high for the cycle after a winner was registered
//   last_gnt             grant code of the access being committed
//   gnt                  combinational winner for the current request set
// Base priority TFT > STN > HOST. A pending STN write is forced after WR_STARVE
// consecutive TFT grants; a pending host access is forced after HOST_STARVE
// consecutive non-host grants. Host force beats STN force. WR_STARVE and
// HOST_STARVE must be at least 1.
module ram_arb_prio
  import ram_arb_pkg::*;
#(
  parameter int unsigned WR_STARVE   = 4,
  parameter int unsigned HOST_STARVE = 16
) (
  input  logic       clk,
  input  logic       rst_x,
  input  logic       tft_req,
  input  logic       stn_req,
  input  logic       host_req,
  input  logic       arb,
  input  logic [1:0] last_gnt,
  output logic [1:0] gnt
);

  localparam int unsigned WCW = (WR_STARVE < 1) ? 1 : $clog2(WR_STARVE + 1);
  localparam int unsigned HCW = (HOST_STARVE < 1) ? 1 : $clog2(HOST_STARVE + 1);
  localparam logic [WCW-1:0] WR_MAX   = WCW'(WR_STARVE);
  localparam logic [HCW-1:0] HOST_MAX = HCW'(HOST_STARVE);

  logic [WCW-1:0] wr_cnt_q, wr_cnt_d;
  logic [HCW-1:0] host_cnt_q, host_cnt_d;
  logic           wr_force, host_force;

  assign wr_force   = stn_req && (wr_cnt_q == WR_MAX);
  assign host_force = host_req && (host_cnt_q == HOST_MAX);

  always_comb begin
    gnt = GNT_NONE;
    if (host_force)    gnt = GNT_HOST;
    else if (wr_force) gnt = GNT_STN;
    else if (tft_req)  gnt = GNT_TFT;
    else if (stn_req)  gnt = GNT_STN;
    else if (host_req) gnt = GNT_HOST;
  end

  // Counters clear whenever their requester is idle, so no stale count survives
  // into a later burst. Increments happen once per access, while it is in ACC.
  always_comb begin
    wr_cnt_d   = wr_cnt_q;
    host_cnt_d = host_cnt_q;
    if (!stn_req) begin
      wr_cnt_d = '0;
    end else if (arb) begin
      if (last_gnt == GNT_STN) begin
        wr_cnt_d = '0;
      end else if (last_gnt == GNT_TFT && wr_cnt_q != WR_MAX) begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end
    if (!host_req) begin
      host_cnt_d = '0;
    end else if (arb) begin
      if (last_gnt == GNT_HOST) begin
        host_cnt_d = '0;
      end else if (last_gnt != GNT_NONE && host_cnt_q != HOST_MAX) begin
        host_cnt_d = host_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      wr_cnt_q   <= '0;
      host_cnt_q <= '0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      host_cnt_q <= host_cnt_d;
    end
  end

endmodule

// File: rtl/ram_arb3.sv
// ram_arb3: sequencer/arbiter for the single external display RAM.
// Ports:
//   clk, rst_x                      clock, async active-low reset
//   tft_rdreq/raddr, tft_rdack/rdata  TFT refill read port
//   stn_wrreq/waddr/wdata, stn_wrack  STN capture write port
//   host_req/we/addr/wdata,
//   host_ack/rdata                  host debug read/write port
//   ram_ce/we/addr/wdata, ram_rdata RAM interface (all outputs registered)
//   tst                             current grant code (0 in IDLE)
// Each access runs IDLE -> ACC -> DONE; the ack pulses in DONE together with
// any read data.
module ram_arb3
  import ram_arb_pkg::*;
#(
  parameter int unsigned AW          = DEF_AW,
  parameter int unsigned DW          = DEF_DW,
  parameter int unsigned WR_STARVE   = 4,
  parameter int unsigned HOST_STARVE = 16
) (
  input  logic          clk,
  input  logic          rst_x,
  input  logic          tft_rdreq,
  input  logic [AW-1:0] tft_raddr,
  output logic          tft_rdack,
  output logic [DW-1:0] tft_rdata,
  input  logic          stn_wrreq,
  input  logic [AW-1:0] stn_waddr,
  input  logic [DW-1:0] stn_wdata,
  output logic          stn_wrack,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  output logic          ram_ce,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [1:0]    tst
);

  state_e        state_q, state_d;
  logic          ram_ce_q, ram_ce_d;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic [1:0]    tst_q, tst_d;
  logic          tft_rdack_q, tft_rdack_d;
  logic          stn_wrack_q, stn_wrack_d;
  logic          host_ack_q, host_ack_d;
  logic [DW-1:0] tft_rdata_q, tft_rdata_d;
  logic [DW-1:0] host_rdata_q, host_rdata_d;
  logic [1:0]    gnt;

  ram_arb_prio #(
    .WR_STARVE  (WR_STARVE),
    .HOST_STARVE(HOST_STARVE)
  ) u_prio (
    .clk     (clk),
    .rst_x   (rst_x),
    .tft_req (tft_rdreq),
    .stn_req (stn_wrreq),
    .host_req(host_req),
    .arb     (state_q == ACC),
    .last_gnt(tst_q),
    .gnt     (gnt)
  );

  always_comb begin
    state_d      = state_q;
    ram_ce_d     = 1'b0;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    tst_d        = tst_q;
    tft_rdack_d  = 1'b0;
    stn_wrack_d  = 1'b0;
    host_ack_d   = 1'b0;
    tft_rdata_d  = tft_rdata_q;
    host_rdata_d = host_rdata_q;
    unique case (state_q)
      IDLE: begin
        tst_d = GNT_NONE;
        if (gnt != GNT_NONE) begin
          state_d  = ACC;
          ram_ce_d = 1'b1;
          tst_d    = gnt;
          case (gnt)
            GNT_TFT: ram_addr_d = tft_raddr;
            GNT_STN: begin
              ram_we_d    = 1'b1;
              ram_addr_d  = stn_waddr;
              ram_wdata_d = stn_wdata;
            end
            GNT_HOST: begin
              ram_we_d   = host_we;
              ram_addr_d = host_addr;
              if (host_we) ram_wdata_d = host_wdata;
            end
            default: ;
          endcase
        end
      end
      ACC: begin
        state_d = DONE;
        // Read data is sampled on the edge entering DONE so it lines up with the ack.
        case (tst_q)
          GNT_TFT: begin
            tft_rdack_d = 1'b1;
            tft_rdata_d = ram_rdata;
          end
          GNT_STN: stn_wrack_d = 1'b1;
          GNT_HOST: begin
            host_ack_d = 1'b1;
            if (!ram_we_q) host_rdata_d = ram_rdata;
          end
          default: ;
        endcase
      end
      DONE: begin
        state_d = IDLE;
        tst_d   = GNT_NONE;
      end
      default: begin
        state_d = IDLE;
        tst_d   = GNT_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_q      <= IDLE;
      ram_ce_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      tst_q        <= GNT_NONE;
      tft_rdack_q  <= 1'b0;
      stn_wrack_q  <= 1'b0;
      host_ack_q   <= 1'b0;
      tft_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      ram_ce_q     <= ram_ce_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      tst_q        <= tst_d;
      tft_rdack_q  <= tft_rdack_d;
      stn_wrack_q  <= stn_wrack_d;
      host_ack_q   <= host_ack_d;
      tft_rdata_q  <= tft_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign ram_ce     = ram_ce_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign tst        = tst_q;
  assign tft_rdack  = tft_rdack_q;
  assign stn_wrack  = stn_wrack_q;
  assign host_ack   = host_ack_q;
  assign tft_rdata  = tft_rdata_q;
  assign host_rdata = host_rdata_q;

endmodule

// File: tb/tb_ram_arb3.sv
// Bench for ram_arb3: a default-parameter instance on a behavioural RAM, and a
// second instance with both starvation limits at 1 for the force-precedence case.
module tb_ram_arb3;
  import ram_arb_pkg::*;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst_x = 1'b0;
  always #5 clk = ~clk;

  logic          tft_rdreq = 0, stn_wrreq = 0, host_req = 0, host_we = 0;
  logic [AW-1:0] tft_raddr = '0, stn_waddr = '0, host_addr = '0;
  logic [DW-1:0] stn_wdata = '0, host_wdata = '0;
  logic          tft_rdack, stn_wrack, host_ack, ram_ce, ram_we;
  logic [DW-1:0] tft_rdata, host_rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;
  logic [1:0]    tst;

  logic          tft_rdreq_f = 0, stn_wrreq_f = 0, host_req_f = 0;
  logic          tft_rdack_f, stn_wrack_f, host_ack_f, ram_ce_f, ram_we_f;
  logic [DW-1:0] tft_rdata_f, host_rdata_f, ram_wdata_f;
  logic [AW-1:0] ram_addr_f;
  logic [1:0]    tst_f;
  logic [DW-1:0] ram_rdata_f = '0;

  ram_arb3 #(.AW(AW), .DW(DW), .WR_STARVE(4), .HOST_STARVE(16)) dut (
    .clk(clk), .rst_x(rst_x),
    .tft_rdreq(tft_rdreq), .tft_raddr(tft_raddr), .tft_rdack(tft_rdack), .tft_rdata(tft_rdata),
    .stn_wrreq(stn_wrreq), .stn_waddr(stn_waddr), .stn_wdata(stn_wdata), .stn_wrack(stn_wrack),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .tst(tst)
  );

  ram_arb3 #(.AW(AW), .DW(DW), .WR_STARVE(1), .HOST_STARVE(1)) dut_f (
    .clk(clk), .rst_x(rst_x),
    .tft_rdreq(tft_rdreq_f), .tft_raddr(13'h0001), .tft_rdack(tft_rdack_f),
    .tft_rdata(tft_rdata_f),
    .stn_wrreq(stn_wrreq_f), .stn_waddr(13'h0002), .stn_wdata(8'h11), .stn_wrack(stn_wrack_f),
    .host_req(host_req_f), .host_we(1'b0), .host_addr(13'h0003), .host_wdata(8'h22),
    .host_ack(host_ack_f), .host_rdata(host_rdata_f),
    .ram_ce(ram_ce_f), .ram_we(ram_we_f), .ram_addr(ram_addr_f), .ram_wdata(ram_wdata_f),
    .ram_rdata(ram_rdata_f), .tst(tst_f)
  );

  // Behavioural RAM: combinational read of the presented address, write on clock.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_ce && ram_we) mem[ram_addr] <= ram_wdata;
  end
  assign ram_rdata = mem[ram_addr];

  int n_tft_ack = 0, n_host_ack = 0, n_we_cyc = 0, n_ce_cyc = 0;
  always @(negedge clk) begin
    if (tft_rdack) n_tft_ack <= n_tft_ack + 1;
    if (host_ack)  n_host_ack <= n_host_ack + 1;
    if (ram_we)    n_we_cyc <= n_we_cyc + 1;
    if (ram_ce)    n_ce_cyc <= n_ce_cyc + 1;
  end

  typedef struct packed {
    logic [1:0]    code;
    logic          chk;
    logic [DW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic exp_t pop_exp();
    exp_t e;
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    return e;
  endfunction

  // Waits (bounded) for the next ack on the selected instance; code 0 on timeout.
  task automatic wait_ack(input bit on_f, input int budget, output logic [1:0] code);
    code = GNT_NONE;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!on_f) begin
        if (tft_rdack) code = GNT_TFT;
        else if (stn_wrack) code = GNT_STN;
        else if (host_ack) code = GNT_HOST;
      end else begin
        if (tft_rdack_f) code = GNT_TFT;
        else if (stn_wrack_f) code = GNT_STN;
        else if (host_ack_f) code = GNT_HOST;
      end
      if (code != GNT_NONE) break;
    end
  endtask

  task automatic test_reset();
    rst_x = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (ram_ce !== 1'b0) begin n_fail++; $display("FAIL reset_ram_ce: got %0h want 0", ram_ce); end
    n_tests++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we: got %0h want 0", ram_we); end
    n_tests++; if (ram_addr !== '0) begin n_fail++; $display("FAIL reset_ram_addr: got %0h want 0", ram_addr); end
    n_tests++; if (ram_wdata !== '0) begin n_fail++; $display("FAIL reset_ram_wdata: got %0h want 0", ram_wdata); end
    n_tests++; if ({tft_rdack, stn_wrack, host_ack} !== 3'b000) begin n_fail++; $display("FAIL reset_acks: got %b want 000", {tft_rdack, stn_wrack, host_ack}); end
    n_tests++; if (tft_rdata !== '0) begin n_fail++; $display("FAIL reset_tft_rdata: got %0h want 0", tft_rdata); end
    n_tests++; if (host_rdata !== '0) begin n_fail++; $display("FAIL reset_host_rdata: got %0h want 0", host_rdata); end
    n_tests++; if (tst !== 2'd0) begin n_fail++; $display("FAIL reset_tst: got %0d want 0", tst); end
    rst_x = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++; if (ram_ce !== 1'b0) begin n_fail++; $display("FAIL idle_ram_ce: got %0h want 0", ram_ce); end
  endtask

  task automatic test_tft_read();
    exp_t e;
    @(negedge clk);
    pre_we = 1'b1; pre_addr = 13'h0123; pre_data = 8'hA5;
    @(negedge clk);
    pre_we = 1'b0;
    tft_rdreq = 1'b1; tft_raddr = 13'h0123;
    exp_q.push_back('{code: GNT_TFT, chk: 1'b1, data: 8'hA5});
    @(negedge clk);  // ACC
    n_tests++; if (ram_ce !== 1'b1) begin n_fail++; $display("FAIL tft_acc_ce: got %0h want 1", ram_ce); end
    n_tests++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL tft_acc_we: got %0h want 0", ram_we); end
    n_tests++; if (ram_addr !== 13'h0123) begin n_fail++; $display("FAIL tft_acc_addr: got %0h want 123", ram_addr); end
    n_tests++; if (tst !== 2'd1) begin n_fail++; $display("FAIL tft_acc_tst: got %0d want 1", tst); end
    @(negedge clk);  // DONE
    e = pop_exp();
    n_tests++; if (tft_rdack !== 1'b1) begin n_fail++; $display("FAIL tft_ack: got %0h want 1", tft_rdack); end
    n_tests++; if (tft_rdata !== e.data) begin n_fail++; $display("FAIL tft_rdata: got %0h want %0h", tft_rdata, e.data); end
    n_tests++; if (ram_ce !== 1'b0) begin n_fail++; $display("FAIL tft_done_ce: got %0h want 0", ram_ce); end
    n_tests++; if (tst !== e.code) begin n_fail++; $display("FAIL tft_done_tst: got %0d want %0d", tst, e.code); end
    tft_rdreq = 1'b0;
    @(negedge clk);  // back in IDLE
    n_tests++; if (tft_rdack !== 1'b0) begin n_fail++; $display("FAIL tft_ack_pulse: got %0h want 0", tft_rdack); end
    n_tests++; if (tst !== 2'd0) begin n_fail++; $display("FAIL tft_idle_tst: got %0d want 0", tst); end
  endtask

  task automatic test_stn_host();
    exp_t e;
    logic [1:0] code;
    int we0;
    @(negedge clk);
    we0 = n_we_cyc;
    stn_wrreq = 1'b1; stn_waddr = 13'h1FFF; stn_wdata = 8'h3C;
    exp_q.push_back('{code: GNT_STN, chk: 1'b0, data: 8'h00});
    @(negedge clk);  // ACC
    n_tests++; if (ram_we !== 1'b1) begin n_fail++; $display("FAIL stn_acc_we: got %0h want 1", ram_we); end
    n_tests++; if (ram_addr !== 13'h1FFF) begin n_fail++; $display("FAIL stn_acc_addr: got %0h want 1fff", ram_addr); end
    n_tests++; if (ram_wdata !== 8'h3C) begin n_fail++; $display("FAIL stn_acc_wdata: got %0h want 3c", ram_wdata); end
    wait_ack(1'b0, 4, code);
    e = pop_exp();
    n_tests++; if (code !== e.code) begin n_fail++; $display("FAIL stn_ack: got %0d want %0d", code, e.code); end
    stn_wrreq = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 13'h1FFF;
    exp_q.push_back('{code: GNT_HOST, chk: 1'b1, data: 8'h3C});
    wait_ack(1'b0, 6, code);
    e = pop_exp();
    n_tests++; if (code !== e.code) begin n_fail++; $display("FAIL host_rd_ack: got %0d want %0d", code, e.code); end
    n_tests++; if (host_rdata !== e.data) begin n_fail++; $display("FAIL host_rdata: got %0h want %0h", host_rdata, e.data); end
    host_req = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (n_we_cyc - we0 !== 1) begin n_fail++; $display("FAIL we_cycles: got %0d want 1", n_we_cyc - we0); end
  endtask

  task automatic test_all_reqs();
    exp_t e;
    logic [1:0] code;
    int wr_m, host_m, first_host;
    logic [1:0] g;
    rst_x = 1'b0;
    @(negedge clk);
    rst_x = 1'b1;
    wr_m = 0; host_m = 0;
    for (int i = 0; i < 40; i++) begin
      if (host_m == 16) g = GNT_HOST;
      else if (wr_m == 4) g = GNT_STN;
      else g = GNT_TFT;
      if (g == GNT_STN) wr_m = 0;
      else if (g == GNT_TFT && wr_m < 4) wr_m++;
      if (g == GNT_HOST) host_m = 0;
      else if (host_m < 16) host_m++;
      exp_q.push_back('{code: g, chk: 1'b0, data: 8'h00});
    end
    tft_rdreq = 1'b1; tft_raddr = 13'h0010;
    stn_wrreq = 1'b1; stn_waddr = 13'h0020; stn_wdata = 8'h77;
    host_req = 1'b1; host_we = 1'b0; host_addr = 13'h0030;
    first_host = 0;
    for (int i = 0; i < 40; i++) begin
      wait_ack(1'b0, 6, code);
      e = pop_exp();
      n_tests++; if (code !== e.code) begin n_fail++; $display("FAIL seq_ack[%0d]: got %0d want %0d", i, code, e.code); end
      n_tests++; if (tst !== e.code) begin n_fail++; $display("FAIL seq_tst[%0d]: got %0d want %0d", i, tst, e.code); end
      if (code == GNT_HOST && first_host == 0) first_host = i + 1;
    end
    tft_rdreq = 1'b0; stn_wrreq = 1'b0; host_req = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (first_host < 1 || first_host > 17) begin n_fail++; $display("FAIL host_wait: got %0d want 1..17", first_host); end
    n_tests++; if (tst !== 2'd0) begin n_fail++; $display("FAIL seq_idle_tst: got %0d want 0", tst); end
  endtask

  task automatic test_force();
    exp_t e;
    logic [1:0] code;
    logic [1:0] pat [8];
    pat = '{GNT_TFT, GNT_HOST, GNT_STN, GNT_HOST, GNT_TFT, GNT_HOST, GNT_STN, GNT_HOST};
    for (int i = 0; i < 8; i++) exp_q.push_back('{code: pat[i], chk: 1'b0, data: 8'h00});
    tft_rdreq_f = 1'b1; stn_wrreq_f = 1'b1; host_req_f = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_ack(1'b1, 6, code);
      e = pop_exp();
      n_tests++; if (code !== e.code) begin n_fail++; $display("FAIL force_ack[%0d]: got %0d want %0d", i, code, e.code); end
      n_tests++; if (tst_f !== e.code) begin n_fail++; $display("FAIL force_tst[%0d]: got %0d want %0d", i, tst_f, e.code); end
    end
    tft_rdreq_f = 1'b0; stn_wrreq_f = 1'b0; host_req_f = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [1:0] code;
    int a0;
    @(negedge clk);
    a0 = n_tft_ack;
    tft_rdreq = 1'b1; tft_raddr = 13'h0123;
    stn_wrreq = 1'b1; stn_waddr = 13'h0042; stn_wdata = 8'h5A;
    @(negedge clk);  // ACC of the TFT read
    n_tests++; if (tst !== 2'd1) begin n_fail++; $display("FAIL rmid_acc_tst: got %0d want 1", tst); end
    #2 rst_x = 1'b0;
    #1;
    n_tests++; if ({ram_ce, ram_we, tst} !== 4'b0000) begin n_fail++; $display("FAIL rmid_ctl: got %b want 0000", {ram_ce, ram_we, tst}); end
    n_tests++; if ({ram_addr, ram_wdata} !== '0) begin n_fail++; $display("FAIL rmid_bus: got %0h want 0", {ram_addr, ram_wdata}); end
    n_tests++; if ({tft_rdack, stn_wrack, host_ack} !== 3'b000) begin n_fail++; $display("FAIL rmid_acks: got %b want 000", {tft_rdack, stn_wrack, host_ack}); end
    n_tests++; if (tft_rdata !== '0) begin n_fail++; $display("FAIL rmid_tft_rdata: got %0h want 0", tft_rdata); end
    tft_rdreq = 1'b0;
    @(negedge clk);
    rst_x = 1'b1;
    exp_q.push_back('{code: GNT_STN, chk: 1'b0, data: 8'h00});
    @(negedge clk);  // arbitration edge has passed
    n_tests++; if (tst !== 2'd2) begin n_fail++; $display("FAIL rmid_grant: got %0d want 2", tst); end
    @(negedge clk);
    code = tft_rdack ? GNT_TFT : stn_wrack ? GNT_STN : host_ack ? GNT_HOST : GNT_NONE;
    e = pop_exp();
    n_tests++; if (code !== e.code) begin n_fail++; $display("FAIL rmid_stn_ack: got %0d want %0d", code, e.code); end
    stn_wrreq = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (n_tft_ack - a0 !== 0) begin n_fail++; $display("FAIL rmid_no_tft_ack: got %0d want 0", n_tft_ack - a0); end
  endtask

  task automatic test_req_drop();
    exp_t e;
    int h0, c0;
    @(negedge clk);
    h0 = n_host_ack; c0 = n_ce_cyc;
    host_req = 1'b1; host_we = 1'b0; host_addr = 13'h1FFF;
    exp_q.push_back('{code: GNT_HOST, chk: 1'b1, data: 8'h3C});
    @(negedge clk);  // ACC
    n_tests++; if (tst !== 2'd3) begin n_fail++; $display("FAIL drop_acc_tst: got %0d want 3", tst); end
    host_req = 1'b0;
    @(negedge clk);  // DONE
    e = pop_exp();
    n_tests++; if (host_ack !== 1'b1) begin n_fail++; $display("FAIL drop_ack: got %0h want 1", host_ack); end
    n_tests++; if (host_rdata !== e.data) begin n_fail++; $display("FAIL drop_rdata: got %0h want %0h", host_rdata, e.data); end
    repeat (4) @(negedge clk);
    n_tests++; if (n_host_ack - h0 !== 1) begin n_fail++; $display("FAIL drop_ack_count: got %0d want 1", n_host_ack - h0); end
    n_tests++; if (n_ce_cyc - c0 !== 1) begin n_fail++; $display("FAIL drop_grants: got %0d want 1", n_ce_cyc - c0); end
    n_tests++; if (tst !== 2'd0) begin n_fail++; $display("FAIL drop_idle_tst: got %0d want 0", tst); end
  endtask

  initial begin
    test_reset();
    test_tft_read();
    test_stn_host();
    test_all_reqs();
    test_force();
    test_reset_mid();
    test_req_drop();
    n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
